// File: rtl/decoder_pkg.sv
// Shared widths, FSM state encodings and width helpers for the decoder job sequencer.
package decoder_pkg;

  localparam int unsigned CW_W_DEF   = 10;
  localparam int unsigned NUM_CW_DEF = 10;
  localparam int unsigned OUT_W_DEF  = 8;
  localparam int unsigned CNT_W_DEF  = 6;

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD  = 3'd1;
  localparam logic [ST_W-1:0] ST_START = 3'd2;
  localparam logic [ST_W-1:0] ST_RUN   = 3'd3;
  localparam logic [ST_W-1:0] ST_FLUSH = 3'd4;
  localparam logic [ST_W-1:0] ST_DONE  = 3'd5;

  // Counter width able to index n values, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/decoder_ctrl_if.sv
// Generic valid/ready data port used for the host codeword input and the packed word output.
interface decoder_ctrl_if #(parameter int unsigned W = 8) ();
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/decoder_ctrl_bit_packer.sv
// Serial-to-parallel packer: MSB-first shift register, single-entry output holding register, drop detect.
module bit_packer
  import decoder_pkg::*;
#(
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             flush,
  input  logic             ovf_clr,
  output logic [OUT_W-1:0] word,
  output logic             word_vld,
  input  logic             word_rdy,
  output logic             ovf,
  output logic             empty
);

  localparam int unsigned BC_W = cnt_w(OUT_W);

  logic [OUT_W-1:0] sreg_q;
  logic [OUT_W-1:0] sreg_n;
  logic [BC_W-1:0]  cnt_q;
  logic [BC_W-1:0]  cnt_n;
  logic             complete_c;
  logic [OUT_W-1:0] done_word_c;

  // Shift in the current bit first so a flush in the same cycle includes it
  always_comb begin
    sreg_n      = sreg_q;
    cnt_n       = cnt_q;
    complete_c  = 1'b0;
    done_word_c = sreg_q;
    if (bit_vld) begin
      sreg_n = {sreg_q[OUT_W-2:0], bit_in};
      if (cnt_q == BC_W'(OUT_W - 1)) begin
        complete_c  = 1'b1;
        done_word_c = sreg_n;
        cnt_n       = '0;
      end else begin
        cnt_n = cnt_q + BC_W'(1);
      end
    end
    if (!complete_c && flush && (cnt_n != '0)) begin
      complete_c  = 1'b1;
      done_word_c = sreg_n << (OUT_W - 32'(cnt_n));
      cnt_n       = '0;
      sreg_n      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q   <= '0;
      cnt_q    <= '0;
      word     <= '0;
      word_vld <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      sreg_q <= sreg_n;
      cnt_q  <= cnt_n;
      if (complete_c) begin
        if (!word_vld || word_rdy) begin
          word     <= done_word_c;
          word_vld <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end else if (word_rdy) begin
        word_vld <= 1'b0;
      end
      if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  assign empty = (cnt_q == '0) && !word_vld;

endmodule

// File: rtl/decoder_ctrl.sv
// Job sequencer: loads NUM_CW codewords into the FIFO, starts the decoder, packs and drains its bits.
module decoder_ctrl
  import decoder_pkg::*;
#(
  parameter int unsigned CW_W   = CW_W_DEF,
  parameter int unsigned NUM_CW = NUM_CW_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  decoder_ctrl_if.slave     cw,
  output logic [CW_W-1:0]   fifo_din,
  output logic              fifo_wr_en,
  input  logic              fifo_full,
  input  logic [CNT_W-1:0]  fifo_count,
  output logic              dec_start,
  input  logic              dec_bin_msg,
  input  logic              dec_msg_rdy,
  input  logic              dec_msg_done,
  decoder_ctrl_if.master    msg,
  output logic              busy,
  output logic              job_done,
  output logic              ovf_err
);

  localparam int unsigned CC_W = cnt_w(NUM_CW + 1);

  logic [ST_W-1:0]  state_q;
  logic [ST_W-1:0]  state_d;
  logic [CC_W-1:0]  cw_cnt_q;
  logic [CC_W-1:0]  cw_cnt_d;
  logic             cw_ready_c;
  logic             accept_c;
  logic             pk_bit_vld_c;
  logic             pk_empty;
  logic [OUT_W-1:0] pk_word;
  logic             pk_word_vld;
  logic             unused_status;

  assign unused_status = ^fifo_count;

  // Host-side acceptance; held low during reset so the FIFO sees no writes
  always_comb begin
    cw_ready_c = 1'b0;
    case (state_q)
      ST_IDLE: cw_ready_c = !fifo_full;
      ST_LOAD: cw_ready_c = !fifo_full && (cw_cnt_q < CC_W'(NUM_CW));
      default: cw_ready_c = 1'b0;
    endcase
    if (rst) begin
      cw_ready_c = 1'b0;
    end
  end

  assign cw.ready   = cw_ready_c;
  assign accept_c   = cw.valid && cw_ready_c;
  assign fifo_din   = cw.data;
  assign fifo_wr_en = accept_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cw_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cw_cnt_q <= cw_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cw_cnt_d = cw_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          cw_cnt_d = CC_W'(1);
          state_d  = (NUM_CW == 1) ? ST_START : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept_c) begin
          cw_cnt_d = cw_cnt_q + CC_W'(1);
          if (cw_cnt_d == CC_W'(NUM_CW)) begin
            state_d = ST_START;
          end
        end
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (dec_msg_done) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (pk_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign dec_start    = (state_q == ST_START);
  assign job_done     = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);
  assign pk_bit_vld_c = dec_msg_rdy && ((state_q == ST_RUN) || (state_q == ST_FLUSH));

  bit_packer #(.OUT_W(OUT_W)) u_packer (
    .clk      (clk),
    .rst      (rst),
    .bit_in   (dec_bin_msg),
    .bit_vld  (pk_bit_vld_c),
    .flush    (state_q == ST_FLUSH),
    .ovf_clr  (state_q == ST_START),
    .word     (pk_word),
    .word_vld (pk_word_vld),
    .word_rdy (msg.ready),
    .ovf      (ovf_err),
    .empty    (pk_empty)
  );

  assign msg.data  = pk_word;
  assign msg.valid = pk_word_vld;

endmodule

// File: tb/tb_decoder_ctrl.sv
// Directed bench for decoder_ctrl with a queue scoreboard on the packed-word output port.
module tb_decoder_ctrl;
  localparam int unsigned CW_W   = 10;
  localparam int unsigned NUM_CW = 10;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned CNT_W  = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [CW_W-1:0]  fifo_din;
  logic             fifo_wr_en;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic             dec_start;
  logic             dec_bin_msg;
  logic             dec_msg_rdy;
  logic             dec_msg_done;
  logic             busy;
  logic             job_done;
  logic             ovf_err;

  decoder_ctrl_if #(.W(CW_W))  cw_if ();
  decoder_ctrl_if #(.W(OUT_W)) msg_if ();

  decoder_ctrl #(.CW_W(CW_W), .NUM_CW(NUM_CW), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cw           (cw_if),
    .fifo_din     (fifo_din),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count),
    .dec_start    (dec_start),
    .dec_bin_msg  (dec_bin_msg),
    .dec_msg_rdy  (dec_msg_rdy),
    .dec_msg_done (dec_msg_done),
    .msg          (msg_if),
    .busy         (busy),
    .job_done     (job_done),
    .ovf_err      (ovf_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] exp_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every accepted word
  always @(negedge clk) begin
    if (fifo_wr_en) wr_cnt++;
    if (dec_start) start_cnt++;
    if (job_done) done_cnt++;
    if (!rst && msg_if.valid && msg_if.ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL msg_word: got %0h expected none", msg_if.data);
      end else begin
        exp_w = exp_q.pop_front();
        check("msg_word", 32'(msg_if.data), 32'(exp_w));
      end
    end
  end

  task automatic load_job(input int stall_at, input int stall_len);
    int acc = 0;
    int stall = 0;
    int guard = 0;
    int base = wr_cnt;
    logic [CW_W-1:0] w;
    while (acc < NUM_CW && guard < 100) begin
      fifo_full   = (acc == stall_at) && (stall < stall_len);
      w           = CW_W'(acc * 37 + 5);
      cw_if.data  = w;
      cw_if.valid = 1'b1;
      #1;
      if (fifo_full) begin
        check("stall_no_write", 32'(fifo_wr_en), 32'd0);
        stall++;
      end else if (fifo_wr_en) begin
        check("fifo_din", 32'(fifo_din), 32'(w));
        acc++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    cw_if.valid = 1'b0;
    fifo_full   = 1'b0;
    check("writes_per_job", 32'(wr_cnt - base), NUM_CW);
    check("cw_ready_after_load", 32'(cw_if.ready), 32'd0);
    check("dec_start_high", 32'(dec_start), 32'd1);
    tick();
    check("dec_start_one_cycle", 32'(dec_start), 32'd0);
    check("ovf_clear_on_start", 32'(ovf_err), 32'd0);
  endtask

  task automatic send_bits(input logic [31:0] val, input int n, input bit with_done);
    for (int i = 0; i < n; i++) begin
      dec_msg_rdy  = 1'b1;
      dec_bin_msg  = val[n-1-i];
      dec_msg_done = with_done && (i == n - 1);
      tick();
    end
    dec_msg_rdy  = 1'b0;
    dec_bin_msg  = 1'b0;
    dec_msg_done = 1'b0;
  endtask

  task automatic wait_job_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (job_done) seen = 1'b1;
      else tick();
    end
    check("job_done_seen", 32'(seen), 32'd1);
    tick();
    check("job_done_pulse", 32'(job_done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b1;
    fifo_full    = 1'b0;
    fifo_count   = '0;
    dec_bin_msg  = 1'b0;
    dec_msg_rdy  = 1'b0;
    dec_msg_done = 1'b0;
    cw_if.data   = '0;
    cw_if.valid  = 1'b0;
    msg_if.ready = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_msg_valid", 32'(msg_if.valid), 32'd0);
    check("rst_cw_ready", 32'(cw_if.ready), 32'd0);
    rst = 1'b0;
    #1;
    check("cw_ready_after_rst", 32'(cw_if.ready), 32'd1);
    tick();

    // Job 1: straight load, one full word
    load_job(-1, 0);
    exp_q.push_back(8'hB2);
    send_bits(32'hB2, 8, 1'b1);
    check("pack_latency_valid", 32'(msg_if.valid), 32'd1);
    check("pack_word", 32'(msg_if.data), 32'hB2);
    wait_job_done();

    // Job 2: FIFO stall mid-load, two full words plus a flushed partial
    load_job(5, 4);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hD0);
    send_bits(32'hA53CD, 20, 1'b1);
    wait_job_done();
    check("no_ovf_job2", 32'(ovf_err), 32'd0);

    // Job 3: consumer stalled across two words, second is dropped
    msg_if.ready = 1'b0;
    load_job(-1, 0);
    exp_q.push_back(8'h81);
    send_bits(32'h817E, 16, 1'b1);
    check("ovf_valid_held", 32'(msg_if.valid), 32'd1);
    check("ovf_old_word_kept", 32'(msg_if.data), 32'h81);
    check("ovf_set", 32'(ovf_err), 32'd1);
    tick();
    tick();
    check("flush_waits_drain", 32'(busy), 32'd1);
    msg_if.ready = 1'b1;
    wait_job_done();
    check("ovf_sticky", 32'(ovf_err), 32'd1);

    // Job 4: reset mid-RUN with a partial word pending
    load_job(-1, 0);
    send_bits(32'h5, 3, 1'b0);
    rst         = 1'b1;
    cw_if.valid = 1'b1;
    tick();
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("midrun_rst_msg_valid", 32'(msg_if.valid), 32'd0);
    tick();
    tick();
    check("midrun_rst_cw_ready", 32'(cw_if.ready), 32'd0);
    cw_if.valid = 1'b0;
    rst         = 1'b0;
    #1;
    check("midrun_post_rst_cw_ready", 32'(cw_if.ready), 32'd1);
    tick();

    // Job 5: partial word from job 4 must not leak into this one
    load_job(-1, 0);
    exp_q.push_back(8'h5A);
    send_bits(32'h5A, 8, 1'b1);
    wait_job_done();

    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("total_writes", 32'(wr_cnt), 32'(5 * NUM_CW));
    check("total_starts", 32'(start_cnt), 32'd5);
    check("total_job_done", 32'(done_cnt), 32'd4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
